// File: rtl/hash_rx_pkg.sv
// Shared types and constants for the hash receiver block.
package hash_rx_pkg;

  localparam int BYTE_W = 8;
  localparam int HASH_W = 64;

  // Frame-assembly FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

endpackage : hash_rx_pkg

// File: rtl/hash_rx_if.sv
// Byte-stream / result bundle between a byte source and the hash receiver.
//
// Handshake: there is no back-pressure. A byte transfers on every rising
// edge where ByteValid=1; Z and Byte are meaningful only in that cycle.
// ExpectedHash is sampled on the edge that accepts the frame's final byte.
// Done/Match/Error/hashValue are registered levels that hold until the next
// accepted byte.
interface hash_rx_if;
  import hash_rx_pkg::*;

  logic [BYTE_W-1:0] Byte;
  logic              ByteValid;
  logic              Z;
  logic [HASH_W-1:0] ExpectedHash;
  logic [HASH_W-1:0] hashValue;
  logic              Done;
  logic              Match;
  logic              Error;

  modport master (
    output Byte, ByteValid, Z, ExpectedHash,
    input  hashValue, Done, Match, Error
  );

  modport slave (
    input  Byte, ByteValid, Z, ExpectedHash,
    output hashValue, Done, Match, Error
  );

endinterface : hash_rx_if

// File: rtl/hash_rx_timer.sv
// Inter-byte gap counter. Counts consecutive enabled cycles; expired_o is
// high during the TIMEOUT-th consecutive enabled cycle so the owner can act
// on that same edge.
module hash_rx_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired_o = enable_i && (count_q == CW'(TIMEOUT - 1));

  // Next count: restart on clear or when the limit is hit, else advance
  always_comb begin
    count_d = count_q;
    if (clear_i || expired_o) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Gap count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : hash_rx_timer

// File: rtl/hash_receiver.sv
// Assembles NUM_BYTES bytes (MSB first) into a hash, checks frame framing
// (end flag on the last byte only, bounded inter-byte gaps) and compares the
// result against ExpectedHash. Results are registered levels.
module hash_receiver
  import hash_rx_pkg::*;
#(
  parameter int NUM_BYTES = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic      Clock,
  input  logic      Reset,
  hash_rx_if.slave  bus,
  output state_t    dbg_state_o
);

  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HASH_W-1:0] shift_q;
  logic [HASH_W-1:0] hash_q;
  logic              done_q;
  logic              match_q;
  logic              error_q;

  logic              last_slot;
  logic [HASH_W-1:0] shift_d;
  logic [HASH_W-1:0] first_d;
  logic              timer_clear;
  logic              timer_enable;
  logic              timer_expired;

  assign last_slot = (cnt_q == CNT_W'(NUM_BYTES - 1));
  assign shift_d   = {shift_q[HASH_W-BYTE_W-1:0], bus.Byte};
  assign first_d   = {{(HASH_W-BYTE_W){1'b0}}, bus.Byte};

  // The gap timer only runs while a frame is open and no byte arrives
  assign timer_enable = (state_q == RECV) && !bus.ByteValid;
  assign timer_clear  = (state_q != RECV) || bus.ByteValid;

  hash_rx_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (Clock),
    .rst_n     (Reset),
    .clear_i   (timer_clear),
    .enable_i  (timer_enable),
    .expired_o (timer_expired)
  );

  // Frame FSM with registered result outputs
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (bus.ByteValid) begin
            done_q  <= 1'b0;
            match_q <= 1'b0;
            if (bus.Z && (NUM_BYTES > 1)) begin
              // An end flag on the opening byte is a frame too short to use
              error_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ERROR;
            end else begin
              error_q <= 1'b0;
              shift_q <= first_d;
              cnt_q   <= CNT_W'(1);
              state_q <= RECV;
            end
          end
        end
        RECV: begin
          if (bus.ByteValid) begin
            if (last_slot && bus.Z) begin
              hash_q  <= shift_d;
              done_q  <= 1'b1;
              match_q <= (shift_d == bus.ExpectedHash);
              cnt_q   <= '0;
              state_q <= DONE;
            end else if (last_slot || bus.Z) begin
              // Missing end flag on the last byte, or end flag too early
              error_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= ERROR;
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + 1'b1;
            end
          end else if (timer_expired) begin
            error_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ERROR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hashValue = hash_q;
  assign bus.Done      = done_q;
  assign bus.Match     = match_q;
  assign bus.Error     = error_q;
  assign dbg_state_o   = state_q;

endmodule : hash_receiver

// File: tb/tb_hash_receiver.sv
// Directed bench for hash_receiver: framing, matching, timeout, reset.
module tb_hash_receiver;
  import hash_rx_pkg::*;

  localparam logic [63:0] HASH_A = 64'h00000652a55328ca;
  localparam logic [63:0] EXP_A  = 64'h652a55328ca;
  localparam logic [63:0] HASH_B = 64'h0000d0ab89039614;
  localparam logic [63:0] EXP_B  = 64'hd0a7798b0879;
  localparam logic [63:0] JUNK   = 64'h1122334455667788;

  logic   Clock;
  logic   Reset;
  state_t dbg_state;
  int     errors;
  int     checks;

  hash_rx_if bus ();

  hash_receiver #(
    .NUM_BYTES (8),
    .TIMEOUT   (16)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drivers: inputs change on the falling edge, outputs are read there too
  task automatic quiet();
    bus.ByteValid = 1'b0;
    bus.Z         = 1'b0;
    bus.Byte      = 8'h00;
  endtask

  task automatic idle(input int n);
    quiet();
    repeat (n) @(negedge Clock);
  endtask

  // Send n bytes of data starting at byte index first (0 = MSB); Z on zpos
  task automatic send_bytes(input logic [63:0] data, input int first,
                            input int n, input int zpos);
    for (int i = first; i < first + n; i++) begin
      bus.Byte      = data[63-8*i -: 8];
      bus.ByteValid = 1'b1;
      bus.Z         = (i == zpos);
      @(negedge Clock);
    end
    quiet();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    quiet();
    bus.ExpectedHash = '0;
    repeat (2) @(negedge Clock);
    checks++;
    if (bus.hashValue !== 64'h0 || bus.Done !== 1'b0 || bus.Match !== 1'b0 ||
        bus.Error !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: hash=%h done=%b match=%b err=%b st=%0d, required 0/0/0/0/IDLE",
               bus.hashValue, bus.Done, bus.Match, bus.Error, dbg_state);
    end
    Reset = 1'b1;
    idle(1);
  endtask

  task automatic test_match();
    bus.ExpectedHash = EXP_A;
    send_bytes(HASH_A, 0, 7, 7);
    checks++;
    if (bus.Done !== 1'b0 || bus.Error !== 1'b0 || dbg_state !== RECV) begin
      errors++;
      $display("FAIL match_midframe: done=%b err=%b st=%0d, required 0/0/RECV",
               bus.Done, bus.Error, dbg_state);
    end
    send_bytes(HASH_A, 7, 1, 7);
    checks++;
    if (bus.Done !== 1'b1 || bus.Match !== 1'b1 || bus.Error !== 1'b0 ||
        bus.hashValue !== HASH_A) begin
      errors++;
      $display("FAIL match_result: done=%b match=%b err=%b hash=%h, required 1/1/0/%h",
               bus.Done, bus.Match, bus.Error, bus.hashValue, HASH_A);
    end
    idle(5);
    checks++;
    if (bus.Done !== 1'b1 || bus.Match !== 1'b1 || bus.hashValue !== HASH_A) begin
      errors++;
      $display("FAIL match_hold: done=%b match=%b hash=%h, required 1/1/%h",
               bus.Done, bus.Match, bus.hashValue, HASH_A);
    end
  endtask

  task automatic test_mismatch();
    bus.ExpectedHash = EXP_B;
    send_bytes(HASH_B, 0, 8, 7);
    checks++;
    if (bus.Done !== 1'b1 || bus.Match !== 1'b0 || bus.Error !== 1'b0 ||
        bus.hashValue !== HASH_B) begin
      errors++;
      $display("FAIL mismatch_result: done=%b match=%b err=%b hash=%h, required 1/0/0/%h",
               bus.Done, bus.Match, bus.Error, bus.hashValue, HASH_B);
    end
    idle(2);
  endtask

  task automatic test_short_frame();
    send_bytes(JUNK, 0, 5, 4);
    checks++;
    if (bus.Error !== 1'b1 || bus.Done !== 1'b0 || bus.hashValue !== HASH_B ||
        dbg_state !== ERROR) begin
      errors++;
      $display("FAIL short_frame: err=%b done=%b hash=%h st=%0d, required 1/0/%h/ERROR",
               bus.Error, bus.Done, bus.hashValue, dbg_state, HASH_B);
    end
    idle(2);
  endtask

  task automatic test_missing_z();
    send_bytes(JUNK, 0, 8, -1);
    checks++;
    if (bus.Error !== 1'b1 || bus.Done !== 1'b0 || bus.hashValue !== HASH_B) begin
      errors++;
      $display("FAIL missing_z: err=%b done=%b hash=%h, required 1/0/%h",
               bus.Error, bus.Done, bus.hashValue, HASH_B);
    end
    idle(2);
  endtask

  task automatic test_z_ignored();
    bus.ExpectedHash = EXP_A;
    send_bytes(HASH_A, 0, 3, 7);
    bus.Z = 1'b1;
    repeat (2) @(negedge Clock);
    bus.Z = 1'b0;
    checks++;
    if (bus.Error !== 1'b0 || bus.Done !== 1'b0 || dbg_state !== RECV) begin
      errors++;
      $display("FAIL z_no_strobe: err=%b done=%b st=%0d, required 0/0/RECV",
               bus.Error, bus.Done, dbg_state);
    end
    send_bytes(HASH_A, 3, 5, 7);
    checks++;
    if (bus.Done !== 1'b1 || bus.Match !== 1'b1 || bus.hashValue !== HASH_A) begin
      errors++;
      $display("FAIL z_ignored_result: done=%b match=%b hash=%h, required 1/1/%h",
               bus.Done, bus.Match, bus.hashValue, HASH_A);
    end
    idle(1);
  endtask

  task automatic test_first_byte_z();
    send_bytes(JUNK, 0, 1, 0);
    checks++;
    if (bus.Error !== 1'b1 || bus.Done !== 1'b0 || bus.Match !== 1'b0 ||
        bus.hashValue !== HASH_A) begin
      errors++;
      $display("FAIL first_byte_z: err=%b done=%b match=%b hash=%h, required 1/0/0/%h",
               bus.Error, bus.Done, bus.Match, bus.hashValue, HASH_A);
    end
    idle(1);
  endtask

  task automatic test_timeout();
    send_bytes(JUNK, 0, 3, -1);
    checks++;
    if (bus.Error !== 1'b0 || dbg_state !== RECV) begin
      errors++;
      $display("FAIL timeout_restart: err=%b st=%0d, required 0/RECV", bus.Error, dbg_state);
    end
    idle(15);
    checks++;
    if (bus.Error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err=%b after 15 idle, required 0", bus.Error);
    end
    idle(1);
    checks++;
    if (bus.Error !== 1'b1 || bus.Done !== 1'b0 || bus.hashValue !== HASH_A) begin
      errors++;
      $display("FAIL timeout_expire: err=%b done=%b hash=%h, required 1/0/%h",
               bus.Error, bus.Done, bus.hashValue, HASH_A);
    end
    bus.ExpectedHash = EXP_A;
    send_bytes(HASH_A, 0, 8, 7);
    checks++;
    if (bus.Done !== 1'b1 || bus.Error !== 1'b0 || bus.Match !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: done=%b err=%b match=%b, required 1/0/1",
               bus.Done, bus.Error, bus.Match);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_frame();
    send_bytes(JUNK, 0, 4, -1);
    Reset         = 1'b0;
    bus.Byte      = 8'hff;
    bus.ByteValid = 1'b1;
    bus.Z         = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if (bus.hashValue !== 64'h0 || bus.Done !== 1'b0 || bus.Match !== 1'b0 ||
        bus.Error !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid: hash=%h done=%b match=%b err=%b st=%0d, required 0/0/0/0/IDLE",
               bus.hashValue, bus.Done, bus.Match, bus.Error, dbg_state);
    end
    quiet();
    Reset = 1'b1;
    idle(3);
    checks++;
    if (bus.Done !== 1'b0 || bus.Error !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_release: done=%b err=%b st=%0d, required 0/0/IDLE",
               bus.Done, bus.Error, dbg_state);
    end
    bus.ExpectedHash = HASH_B;
    send_bytes(HASH_B, 0, 8, 7);
    checks++;
    if (bus.Done !== 1'b1 || bus.Match !== 1'b1 || bus.Error !== 1'b0 ||
        bus.hashValue !== HASH_B) begin
      errors++;
      $display("FAIL reset_then_frame: done=%b match=%b err=%b hash=%h, required 1/1/0/%h",
               bus.Done, bus.Match, bus.Error, bus.hashValue, HASH_B);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    bus.ExpectedHash = EXP_A;
    send_bytes(HASH_A, 0, 8, 7);
    checks++;
    if (bus.Done !== 1'b1 || bus.hashValue !== HASH_A || bus.Match !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: done=%b match=%b hash=%h, required 1/1/%h",
               bus.Done, bus.Match, bus.hashValue, HASH_A);
    end
    bus.ExpectedHash = HASH_B;
    send_bytes(HASH_B, 0, 1, 7);
    checks++;
    if (bus.Done !== 1'b0 || bus.Match !== 1'b0 || bus.Error !== 1'b0 ||
        bus.hashValue !== HASH_A) begin
      errors++;
      $display("FAIL b2b_drop: done=%b match=%b err=%b hash=%h, required 0/0/0/%h",
               bus.Done, bus.Match, bus.Error, bus.hashValue, HASH_A);
    end
    send_bytes(HASH_B, 1, 7, 7);
    checks++;
    if (bus.Done !== 1'b1 || bus.Match !== 1'b1 || bus.hashValue !== HASH_B) begin
      errors++;
      $display("FAIL b2b_second: done=%b match=%b hash=%h, required 1/1/%h",
               bus.Done, bus.Match, bus.hashValue, HASH_B);
    end
    idle(2);
  endtask

  // Sequencer and final report
  initial begin
    errors = 0;
    checks = 0;
    Reset  = 1'b0;
    quiet();
    bus.ExpectedHash = '0;
    test_reset();
    test_match();
    test_mismatch();
    test_short_frame();
    test_missing_z();
    test_z_ignored();
    test_first_byte_z();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hash_receiver

// File: doc/hash_receiver.md
HASH_RECEIVER -- requirements
Module: hash_receiver

Interface
REQ-001 Parameter: NUM_BYTES, 8, bytes per hash frame; hash width is NUM_BYTES*8 = 64.
REQ-002 Parameter: TIMEOUT, 16, maximum idle cycles allowed between bytes inside a frame.
REQ-003 Clock  input  1  single clock; all logic on the rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 Byte  input  8  received byte, sampled only when ByteValid=1.
REQ-006 ByteValid  input  1  byte strobe; one byte per cycle high.
REQ-007 Z  input  1  end-of-frame flag; qualified by ByteValid and marks the last byte.
REQ-008 ExpectedHash  input  64  reference hash, sampled on the frame-completing cycle.
REQ-009 hashValue  output  64  last successfully received hash.
REQ-010 Done  output  1  level; a good frame is complete.
REQ-011 Match  output  1  level; hashValue==ExpectedHash at completion; valid only while Done=1.
REQ-012 Error  output  1  level; the frame was malformed or timed out.

Function
REQ-013 FSM states SHALL be IDLE, RECV, DONE, ERROR.
REQ-014 Byte order SHALL be MSB first: each accepted byte is placed with shift = {shift[55:0], Byte}.
REQ-015 IDLE/DONE/ERROR + ByteValid SHALL: load shift={56'b0,Byte}, cnt=1, clear Done/Match/Error, go RECV.
REQ-016 Exception to REQ-015: if that first byte has Z=1 and NUM_BYTES>1, the FSM SHALL go to ERROR and set Error=1.
REQ-017 RECV + ByteValid with cnt<NUM_BYTES-1 and Z=0: shift in the byte, cnt++, reset the gap timer.
REQ-018 RECV + ByteValid with cnt==NUM_BYTES-1 and Z=1 SHALL take one cycle and then:
- hashValue = assembled 64 bits;
- Done=1;
- Match=(assembled==ExpectedHash);
- go DONE.
REQ-019 RECV + ByteValid, Z=1, cnt<NUM_BYTES-1 (short frame): Error=1, go ERROR, hashValue unchanged.
REQ-020 RECV + ByteValid, Z=0, cnt==NUM_BYTES-1 (missing end flag): Error=1, go ERROR, hashValue unchanged.
REQ-021 RECV with no ByteValid for TIMEOUT consecutive cycles: Error=1, go ERROR, hashValue unchanged.
REQ-022 Z without ByteValid SHALL be ignored in all states.
REQ-023 DONE and ERROR SHALL hold all outputs until the next ByteValid, which starts a new frame per REQ-015 with no dead cycle.
REQ-024 Done and Error SHALL never be high simultaneously.
REQ-025 Output latency SHALL be exactly 1 cycle after the final byte's strobe cycle.

Reset
REQ-026 Reset=0 at a rising edge SHALL set:
- state=IDLE;
- hashValue=0;
- Done=0, Match=0, Error=0;
- cnt=0, timer=0, shift=0.
REQ-027 Reset mid-frame SHALL discard partial data; no Done or Error results from the aborted frame.
REQ-028 ByteValid while Reset=0 SHALL be ignored.

Structure
REQ-029 Package hash_rx_pkg SHALL hold:
- state enum (IDLE, RECV, DONE, ERROR);
- BYTE_W=8;
- HASH_W=64 constant.
REQ-030 Sub-module hash_rx_timer SHALL implement the gap counter (inputs: clear, enable; output: expired at TIMEOUT); everything else stays in hash_receiver.

Verification
REQ-031 Bytes 00 00 06 52 a5 53 28 ca, Z on the 8th, ExpectedHash=64'h652a55328ca -> next cycle Done=1, Match=1, hashValue=64'h00000652a55328ca.
REQ-032 Bytes 00 00 d0 ab 89 03 96 14, Z on the 8th, ExpectedHash=64'hd0a7798b0879 -> Done=1, Match=0, hashValue=64'h0000d0ab89039614.
REQ-033 Five bytes with Z on the 5th -> Error=1, Done=0, hashValue keeps the prior value.
REQ-034 Three bytes, then ByteValid low for 16 cycles -> Error=1 on cycle 16; a following good frame -> Done=1, Error=0.
REQ-035 Reset=0 after 4 bytes, then release and send a full good frame -> only that frame reported; outputs 0 during reset.
REQ-036 Two good frames back-to-back (byte 1 of frame 2 in the cycle after Done rises) -> Done drops for the frame-2 bytes, then rises with the second hash.
